acc_sequencer: RTL and testbench
================================

ACC_SEQUENCER -- requirements
Module: acc_sequencer

Interface
REQ-001 Parameter CNT_W, default 16, width of length/count configuration and internal counters.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  one-cycle job launch request; sampled only in IDLE.
REQ-005 cfg_acc_len  input  CNT_W  accumulation terms per output pixel; latched on accepted start.
REQ-006 cfg_pix_num  input  CNT_W  output pixels in job; latched on accepted start.
REQ-007 busy  output  1  high from the cycle after accepted start until done.
REQ-008 done  output  1  one-cycle pulse at job completion.
REQ-009 s_valid  input  1  upstream partial-product beat valid.
REQ-010 s_ready  output  1  sequencer accepts beat; a beat is accepted when s_valid && s_ready.
REQ-011 acc_first  output  1  drives accumulator First_Compute_Complete: load instead of add.
REQ-012 acc_gate  output  1  datapath zero-mux select: 1 passes partial product, 0 forces accumulator input to zero.
REQ-013 m_valid  output  1  accumulator output holds a completed pixel sum.
REQ-014 m_ready  input  1  downstream accepts completed sum when m_valid && m_ready.

Function
REQ-015 States: IDLE, RUN, DRAIN; IDLE->RUN on start; RUN->DRAIN on acceptance of last beat of last pixel; DRAIN->IDLE on final m_valid && m_ready, with done high that same transition cycle+1 (registered).
REQ-016 cfg_acc_len of 0 is treated as 1; cfg_pix_num of 0 yields done pulse one cycle after start, busy high for exactly that one cycle, no beats accepted.
REQ-017 tap counter (0..acc_len-1) increments per accepted beat, wraps to 0 after last term; pixel counter increments on each wrap.
REQ-018 acc_gate = accepted beat (combinational, same cycle); never high outside RUN.
REQ-019 acc_first = accepted beat && tap counter == 0; acc_first implies acc_gate.
REQ-020 m_valid is registered: set on the edge that loads the last term of a pixel, cleared on the edge of m_valid && m_ready unless a new last term is loaded on that same edge.
REQ-021 s_ready = (state == RUN) && !(m_valid && !m_ready); i.e. beats are stalled while an unaccepted result is held, preserving accumulator contents (input gated to zero, acc_first low).
REQ-022 In the cycle m_valid && m_ready, a first beat of the next pixel may be accepted (full throughput, acc_len=1 gives one pixel per cycle).
REQ-023 start while busy is ignored; cfg inputs changing mid-job have no effect.
REQ-024 Latency: last beat accepted at cycle t -> m_valid high at t+1; final handshake at cycle u -> done at u+1.

Reset
REQ-025 rst sets state IDLE, counters 0, busy 0, done 0, m_valid 0; s_ready, acc_first, acc_gate evaluate to 0.
REQ-026 rst asserted mid-job aborts the job with no done pulse; the next start after rst deassertion runs normally.

Structure
REQ-027 CNT_W default and state encoding constants belong in the shared Para.v defines.
REQ-028 One sub-module, wrap_counter (enable, limit, count, wrap), instantiated twice for tap and pixel counters.

Verification
REQ-029 acc_len=3, pix_num=2, s_valid always 1, m_ready always 1 -> acc_first at beats 0,3; m_valid at cycles after beats 2,5; done 1 cycle after second handshake.
REQ-030 acc_len=1, pix_num=4, continuous traffic -> acc_first every accepted beat, m_valid high 4 consecutive cycles, done once.
REQ-031 acc_len=2, pix_num=2, m_ready held 0 for 5 cycles after first sum -> s_ready 0, acc_gate 0 those cycles, accumulator value unchanged, resumes on m_ready.
REQ-032 s_valid random 50% -> acc_gate matches accepted beats exactly; sums equal reference sum per pixel.
REQ-033 pix_num=0 -> done 1 cycle after start, no s_ready; start pulsed during busy -> ignored.
REQ-034 rst asserted mid-pixel -> all outputs 0 next cycle, no done; new job completes correctly.

Source files
------------

// File: rtl/acc_sequencer_pkg.sv
// Shared constants and state encoding for the accumulation sequencer.
package acc_sequencer_pkg;

  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/acc_sequencer_wrap_counter.sv
// Modulo counter 0..limit-1 with a combinational wrap flag on the enabled terminal count.
module wrap_counter
  import acc_sequencer_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_limit,
  output logic [CNT_W-1:0] o_count,
  output logic             o_wrap
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] r_count;

  assign o_count = r_count;
  assign o_wrap  = i_en && (r_count == (i_limit - ONE));

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= o_wrap ? '0 : (r_count + ONE);
    end
  end

endmodule

// File: rtl/acc_sequencer.sv
// Control sequencer for a pixel accumulator: counts taps/pixels, gates the
// accumulator input and holds each completed sum until downstream takes it.
module acc_sequencer
  import acc_sequencer_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] cfg_acc_len,
  input  logic [CNT_W-1:0] cfg_pix_num,
  output logic             busy,
  output logic             done,
  input  logic             s_valid,
  output logic             s_ready,
  output logic             acc_first,
  output logic             acc_gate,
  output logic             m_valid,
  input  logic             m_ready
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  function automatic logic [CNT_W-1:0] eff_len(input logic [CNT_W-1:0] len);
    return (len == '0) ? ONE : len;
  endfunction

  state_t           r_state;
  logic             r_busy;
  logic             r_done;
  logic             r_m_valid;
  logic [CNT_W-1:0] r_acc_len;
  logic [CNT_W-1:0] r_pix_num;

  logic             w_start;
  logic             w_accept;
  logic             w_m_hs;
  logic [CNT_W-1:0] w_tap_cnt;
  logic             w_tap_wrap;
  logic [CNT_W-1:0] w_pix_cnt;
  logic             w_pix_wrap;
  logic             w_last;

  // A held, unaccepted sum stalls input so the accumulator keeps its value.
  assign w_start  = start && (r_state == ST_IDLE) && !r_busy;
  assign s_ready  = (r_state == ST_RUN) && !(r_m_valid && !m_ready);
  assign w_accept = s_valid && s_ready;
  assign w_m_hs   = r_m_valid && m_ready;
  assign w_last   = w_tap_wrap && w_pix_wrap;

  assign acc_gate  = w_accept;
  assign acc_first = w_accept && (w_tap_cnt == '0);
  assign m_valid   = r_m_valid;
  assign busy      = r_busy;
  assign done      = r_done;

  wrap_counter #(.CNT_W(CNT_W)) u_tap_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_start),
    .i_en    (w_accept),
    .i_limit (r_acc_len),
    .o_count (w_tap_cnt),
    .o_wrap  (w_tap_wrap)
  );

  wrap_counter #(.CNT_W(CNT_W)) u_pix_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_start),
    .i_en    (w_tap_wrap),
    .i_limit (r_pix_num),
    .o_count (w_pix_cnt),
    .o_wrap  (w_pix_wrap)
  );

  always_ff @(posedge clk) begin
    if (w_start) begin
      r_acc_len <= eff_len(cfg_acc_len);
      r_pix_num <= cfg_pix_num;
    end
  end

  // busy stays up through the done cycle and drops on the following edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_m_valid <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_done) r_busy <= 1'b0;
      if (w_tap_wrap)  r_m_valid <= 1'b1;
      else if (w_m_hs) r_m_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_busy <= 1'b1;
            if (cfg_pix_num == '0) r_done  <= 1'b1;
            else                   r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (w_last) r_state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (w_m_hs) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  logic w_unused;
  assign w_unused = ^w_pix_cnt;

endmodule

// File: tb/tb_acc_sequencer.sv
// Directed job table plus reset sequences for acc_sequencer, with a datapath model.
module tb_acc_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] cfg_acc_len;
  logic [15:0] cfg_pix_num;
  logic        busy;
  logic        done;
  logic        s_valid;
  logic        s_ready;
  logic        acc_first;
  logic        acc_gate;
  logic        m_valid;
  logic        m_ready;

  int checks;
  int fails;
  int acc;
  int s_data;

  typedef struct {
    int len;
    int pix;
    int svm;        // 0: s_valid always 1, 1: random
    int mrm;        // 0: m_ready always 1, 1: random, 2: stall 5 cycles after first sum
    int exp_beats;
    int exp_pix;
  } vec_t;

  vec_t tbl[6];

  acc_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .cfg_acc_len (cfg_acc_len),
    .cfg_pix_num (cfg_pix_num),
    .busy        (busy),
    .done        (done),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .acc_first   (acc_first),
    .acc_gate    (acc_gate),
    .m_valid     (m_valid),
    .m_ready     (m_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  function automatic int exp_sum(input int L, input int p);
    int b;
    b = p * L;
    return 3 * (L * b + (L * (L - 1)) / 2) + L;
  endfunction

  task automatic run_job(input int len, input int pix, input int svm, input int mrm,
                         input int ebeats, input int epix);
    int  L, nacc, nout, ndone, ngate, nhs, stall, acc_hold;
    bit  run, mv, e_done, e_busy, fin, armed, sv, mr, er, mhs, g, f;
    L = (len == 0) ? 1 : len;
    @(negedge clk);
    start = 1'b1; cfg_acc_len = 16'(len); cfg_pix_num = 16'(pix);
    s_valid = 1'b0; m_ready = 1'b1;
    #1;
    chk("start_busy", {31'd0, busy}, 0);
    chk("start_sready", {31'd0, s_ready}, 0);
    @(posedge clk);
    run = (pix != 0); mv = 0; e_done = (pix == 0); e_busy = 1;
    nacc = 0; nout = 0; ndone = 0; ngate = 0; nhs = 0;
    stall = 0; armed = 0; fin = 0; acc_hold = 0;
    for (int cyc = 0; cyc < 600 && !fin; cyc++) begin
      @(negedge clk);
      start = (cyc == 2 && pix != 0);
      cfg_acc_len = 16'(7 + cyc);
      cfg_pix_num = 16'd9;
      sv = (svm == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      if (mrm == 0)      mr = 1'b1;
      else if (mrm == 1) mr = 1'($urandom_range(0, 1));
      else               mr = (stall == 0);
      s_valid = sv; m_ready = mr; s_data = 3 * nacc + 1;
      #1;
      er = run && !(mv && !mr);
      chk("s_ready", {31'd0, s_ready}, {31'd0, er});
      chk("acc_gate", {31'd0, acc_gate}, {31'd0, sv && er});
      chk("acc_first", {31'd0, acc_first}, {31'd0, sv && er && (nacc % L == 0)});
      chk("m_valid", {31'd0, m_valid}, {31'd0, mv});
      chk("done", {31'd0, done}, {31'd0, e_done});
      chk("busy", {31'd0, busy}, {31'd0, e_busy});
      if (stall > 0) chk("stall_acc_hold", acc, acc_hold);
      mhs = mv && mr;
      if (mhs) chk("pixel_sum", acc, exp_sum(L, nout));
      if (done) ndone++;
      if (acc_gate) ngate++;
      if (m_valid && m_ready) nhs++;
      g = acc_gate; f = acc_first;
      @(posedge clk);
      if (g) acc = f ? s_data : acc + s_data;
      if (e_done) begin fin = 1; e_busy = 0; end
      e_done = mhs && (nout + 1 == pix);
      if (sv && er && ((nacc + 1) % L == 0)) mv = 1;
      else if (mhs)                          mv = 0;
      if (mhs) nout++;
      if (sv && er) nacc++;
      if (nacc == L * pix) run = 0;
      if (mrm == 2) begin
        if (stall > 0) stall--;
        else if (!armed && mv) begin stall = 5; armed = 1; acc_hold = acc; end
      end
    end
    start = 1'b0;
    chk("job_finished", {31'd0, fin}, 1);
    chk("beats_gated", ngate, ebeats);
    chk("sums_taken", nhs, epix);
    chk("done_count", ndone, 1);
    @(negedge clk);
    s_valid = 1'b0;
    #1;
    chk("post_busy", {31'd0, busy}, 0);
    chk("post_done", {31'd0, done}, 0);
  endtask

  initial begin
    checks = 0; fails = 0; acc = 0; s_data = 0;
    rst = 1'b1; start = 1'b0; cfg_acc_len = '0; cfg_pix_num = '0;
    s_valid = 1'b1; m_ready = 1'b0;

    tbl[0] = '{3, 2, 0, 0, 6, 2};
    tbl[1] = '{1, 4, 0, 0, 4, 4};
    tbl[2] = '{2, 2, 0, 2, 4, 2};
    tbl[3] = '{4, 3, 1, 1, 12, 3};
    tbl[4] = '{0, 3, 1, 0, 3, 3};
    tbl[5] = '{5, 0, 0, 0, 0, 0};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_m_valid", {31'd0, m_valid}, 0);
    chk("rst_s_ready", {31'd0, s_ready}, 0);
    chk("rst_acc_gate", {31'd0, acc_gate}, 0);
    chk("rst_acc_first", {31'd0, acc_first}, 0);
    rst = 1'b0; s_valid = 1'b0; m_ready = 1'b1;

    for (int i = 0; i < 6; i++)
      run_job(tbl[i].len, tbl[i].pix, tbl[i].svm, tbl[i].mrm, tbl[i].exp_beats, tbl[i].exp_pix);

    // Abort a job mid-pixel with reset, then confirm a clean restart.
    @(negedge clk);
    start = 1'b1; cfg_acc_len = 16'd4; cfg_pix_num = 16'd2;
    @(negedge clk);
    start = 1'b0; s_valid = 1'b1; m_ready = 1'b1;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 0);
    chk("abort_done", {31'd0, done}, 0);
    chk("abort_m_valid", {31'd0, m_valid}, 0);
    chk("abort_s_ready", {31'd0, s_ready}, 0);
    chk("abort_acc_gate", {31'd0, acc_gate}, 0);
    chk("abort_acc_first", {31'd0, acc_first}, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      chk("abort_no_done", {31'd0, done}, 0);
      chk("abort_idle_busy", {31'd0, busy}, 0);
    end
    run_job(2, 3, 0, 0, 6, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
